// File: rtl/gossamer_tx_if.sv
// Link bundle between the dibit framer and its client/receiver.
// The framer uses the master view; the environment uses the slave view.
interface gossamer_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              disconnection;
    logic [1:0]        gossamer;
    logic              two_guitars;
    logic              nothing_of_note;
    logic              tx_done;
    logic              tx_error;
    logic              busy;

    modport master (
        input  tx_data, tx_valid, nothing_of_note,
        output tx_ready, disconnection, gossamer, two_guitars, tx_done, tx_error, busy
    );

    modport slave (
        output tx_data, tx_valid, nothing_of_note,
        input  tx_ready, disconnection, gossamer, two_guitars, tx_done, tx_error, busy
    );
endinterface

// File: rtl/gossamer_tx.sv
// Dibit link framer: start marker, MSB-first 2-bit symbols, then a bounded
// wait for acknowledge with a fixed number of retransmissions.
module gossamer_tx #(
    parameter int DATA_W      = 8,
    parameter int ACK_TIMEOUT = 16,
    parameter int MAX_RETRY   = 3
) (
    input  logic          clk,
    input  logic          resetb,
    gossamer_tx_if.master lnk
);
    localparam int NSYM = DATA_W / 2;
    localparam int SCW  = $clog2(NSYM) + 1;
    localparam int TCW  = $clog2(ACK_TIMEOUT) + 1;
    localparam int RCW  = $clog2(MAX_RETRY + 1) + 1;

    typedef enum logic [1:0] {IDLE, START, SHIFT, WAIT_ACK} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] sr;
    logic [SCW-1:0]    scnt;
    logic [TCW-1:0]    tcnt;
    logic [RCW-1:0]    rcnt;
    logic              done_q, err_q;
    logic              done_nxt, err_nxt;
    logic              accept, last_sym, timeout, can_retry;
    logic              ready_c, disc_c, tg_c;
    logic [1:0]        sym_c;

    assign ready_c   = (state == IDLE) && !resetb;
    assign last_sym  = (scnt == SCW'(NSYM - 1));
    assign timeout   = (tcnt == TCW'(ACK_TIMEOUT - 1));
    assign can_retry = (rcnt < RCW'(MAX_RETRY));

    always_ff @(posedge clk) begin
        if (resetb) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        accept    = 1'b0;
        disc_c    = 1'b0;
        tg_c      = 1'b0;
        sym_c     = 2'b00;
        case (state)
            IDLE: begin
                if (lnk.tx_valid && ready_c) begin
                    accept    = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                disc_c    = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                tg_c  = 1'b1;
                sym_c = sr[DATA_W-1 -: 2];
                if (last_sym) state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                // An ack in the final timeout cycle still completes the frame.
                if (lnk.nothing_of_note) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else if (timeout) begin
                    if (can_retry) begin
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                        err_nxt   = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetb) begin
            word   <= '0;
            sr     <= '0;
            scnt   <= '0;
            tcnt   <= '0;
            rcnt   <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= done_nxt;
            err_q  <= err_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        word <= lnk.tx_data;
                        sr   <= lnk.tx_data;
                        rcnt <= '0;
                    end
                end
                START: begin
                    // Reload from the held copy so every retry resends the same word.
                    sr   <= word;
                    scnt <= '0;
                end
                SHIFT: begin
                    sr   <= sr << 2;
                    scnt <= scnt + SCW'(1);
                    if (last_sym) tcnt <= '0;
                end
                WAIT_ACK: begin
                    tcnt <= tcnt + TCW'(1);
                    if (!lnk.nothing_of_note && timeout && can_retry)
                        rcnt <= rcnt + RCW'(1);
                end
                default: ;
            endcase
        end
    end

    assign lnk.tx_ready      = ready_c;
    assign lnk.disconnection = disc_c;
    assign lnk.gossamer      = sym_c;
    assign lnk.two_guitars   = tg_c;
    assign lnk.tx_done       = done_q;
    assign lnk.tx_error      = err_q;
    assign lnk.busy          = (state != IDLE);
endmodule

// File: tb/tb_gossamer_tx.sv
// Bench for gossamer_tx: per-cycle plans checked against an attempt/window
// model of the framing protocol, plus table vectors and corner sequences.
module tb_gossamer_tx;
    localparam int DW = 8, AT = 16, MR = 3, NS = DW / 2, MAXC = 256;

    logic clk = 1'b0;
    logic resetb;
    gossamer_tx_if #(.DATA_W(DW)) lnk();
    gossamer_tx #(.DATA_W(DW), .ACK_TIMEOUT(AT), .MAX_RETRY(MR)) dut (
        .clk(clk), .resetb(resetb), .lnk(lnk)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    // per-cycle drive plan and expected outputs
    bit          d_val[MAXC];
    logic [DW-1:0] d_dat[MAXC];
    bit          d_ack[MAXC];
    bit          d_rst[MAXC];
    bit          x_chk[MAXC];
    bit          x_rdy[MAXC], x_busy[MAXC], x_disc[MAXC], x_tg[MAXC], x_done[MAXC], x_err[MAXC];
    logic [1:0]  x_sym[MAXC];
    logic [1:0]  o_sym[MAXC];
    int          o_done, o_err, o_disc;

    typedef struct {
        logic [7:0] data;
        int         ack_lo, ack_hi;
        bit         noise;
        int         done_c, err_c, ndisc;
    } vec_t;
    vec_t tv[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic clear_plan();
        for (int c = 0; c < MAXC; c++) begin
            d_val[c] = 0; d_dat[c] = '0; d_ack[c] = 0; d_rst[c] = 0;
            x_chk[c] = 1; x_rdy[c] = 1; x_busy[c] = 0; x_disc[c] = 0;
            x_tg[c] = 0; x_done[c] = 0; x_err[c] = 0; x_sym[c] = 2'b00;
        end
    endtask

    // Attempt t starts at a marker, NS symbols follow, then a window of AT
    // cycles; the first ack in a window ends the frame one cycle later.
    task automatic model(input logic [DW-1:0] d, input int base, output int e);
        int t;
        bit acked;
        t = base + 1; acked = 0; e = -1;
        for (int a = 0; a <= MR && !acked; a++) begin
            x_disc[t] = 1; x_busy[t] = 1;
            for (int k = 0; k < NS; k++) begin
                x_tg[t+1+k] = 1; x_busy[t+1+k] = 1;
                x_sym[t+1+k] = 2'((d >> (DW - 2 - 2*k)) & 3);
            end
            for (int w = t + NS + 1; w <= t + NS + AT && !acked; w++) begin
                x_busy[w] = 1;
                if (d_ack[w]) begin acked = 1; e = w + 1; x_done[e] = 1; end
            end
            t += 1 + NS + AT;
        end
        if (!acked) begin e = t; x_err[e] = 1; end
        for (int c = base + 1; c < e; c++) x_rdy[c] = 0;
    endtask

    task automatic run_cycles(input int n, input string name);
        o_done = -1; o_err = -1; o_disc = 0;
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            resetb = d_rst[c];
            lnk.tx_valid = d_val[c];
            lnk.tx_data = d_dat[c];
            lnk.nothing_of_note = d_ack[c];
            @(negedge clk);
            o_sym[c] = lnk.gossamer;
            if (lnk.tx_done && o_done < 0) o_done = c;
            if (lnk.tx_error && o_err < 0) o_err = c;
            if (lnk.disconnection) o_disc++;
            if (x_chk[c])
                check($sformatf("%s c%0d", name, c),
                      {24'd0, lnk.tx_ready, lnk.busy, lnk.disconnection, lnk.two_guitars,
                       lnk.tx_done, lnk.tx_error, lnk.gossamer},
                      {24'd0, x_rdy[c], x_busy[c], x_disc[c], x_tg[c],
                       x_done[c], x_err[c], x_sym[c]});
        end
    endtask

    task automatic run_frame(input logic [DW-1:0] d, input string name, input bit noise, output int e);
        d_val[0] = 1; d_dat[0] = d;
        model(d, 0, e);
        if (noise)
            for (int c = 1; c < e; c++) begin
                d_val[c] = 1'($urandom_range(0, 1));
                d_dat[c] = DW'($urandom);
            end
        run_cycles(e + 2, name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int e, e2;
        resetb = 1; lnk.tx_valid = 0; lnk.tx_data = '0; lnk.nothing_of_note = 0;

        tv[0] = '{8'hB4,  6,  6, 0,  7, -1, 1};
        tv[1] = '{8'h5A, 27, 27, 0, 28, -1, 2};
        tv[2] = '{8'hC3,  1,  0, 0, -1, 85, 4};
        tv[3] = '{8'h3C,  1,  5, 0, -1, 85, 4};
        tv[4] = '{8'h96, 21, 21, 0, 22, -1, 1};
        tv[5] = '{8'hA5, 27, 27, 1, 28, -1, 2};

        // reset state, valid and ack pulsed while in reset
        clear_plan();
        for (int c = 0; c < 4; c++) begin
            d_rst[c] = 1; x_rdy[c] = 0; d_val[c] = 1; d_dat[c] = 8'h77; d_ack[c] = 1;
        end
        run_cycles(7, "reset");

        for (int i = 0; i < 6; i++) begin
            clear_plan();
            for (int c = tv[i].ack_lo; c <= tv[i].ack_hi; c++) d_ack[c] = 1;
            run_frame(tv[i].data, $sformatf("vec%0d", i), tv[i].noise, e);
            check($sformatf("vec%0d done_cycle", i), 32'(o_done), 32'(tv[i].done_c));
            check($sformatf("vec%0d err_cycle", i), 32'(o_err), 32'(tv[i].err_c));
            check($sformatf("vec%0d markers", i), 32'(o_disc), 32'(tv[i].ndisc));
            if (tv[i].data == 8'hB4)
                check("b4 symbols", {24'd0, o_sym[2], o_sym[3], o_sym[4], o_sym[5]},
                      {24'd0, 2'd2, 2'd3, 2'd1, 2'd0});
        end

        // back-to-back: valid held, second accept in the tx_done cycle
        clear_plan();
        for (int c = 0; c < 7; c++) begin d_val[c] = 1; d_dat[c] = 8'h00; end
        for (int c = 7; c < 14; c++) begin d_val[c] = 1; d_dat[c] = 8'hFF; end
        d_ack[6] = 1; d_ack[13] = 1;
        model(8'h00, 0, e);
        model(8'hFF, 7, e2);
        run_cycles(e2 + 2, "b2b");
        check("b2b first done", 32'(o_done), 32'd7);
        check("b2b markers", 32'(o_disc), 32'd2);
        check("b2b second syms", {24'd0, o_sym[9], o_sym[10], o_sym[11], o_sym[12]}, 32'hFF);

        // reset during SHIFT aborts silently
        clear_plan();
        d_val[0] = 1; d_dat[0] = 8'hE1; d_ack[6] = 1;
        model(8'hE1, 0, e);
        d_rst[3] = 1; d_rst[4] = 1;
        x_chk[3] = 0;
        for (int c = 4; c < MAXC; c++) begin
            x_busy[c] = 0; x_disc[c] = 0; x_tg[c] = 0; x_done[c] = 0; x_err[c] = 0;
            x_sym[c] = 2'b00; x_rdy[c] = (c >= 5);
        end
        run_cycles(30, "midrst");
        check("midrst no done", 32'(o_done), 32'hFFFF_FFFF);
        check("midrst no err", 32'(o_err), 32'hFFFF_FFFF);
        clear_plan();
        d_ack[6] = 1;
        run_frame(8'h5C, "postrst", 0, e);
        check("postrst done", 32'(o_done), 32'd7);

        // randomized frames against the model
        for (int i = 0; i < 25; i++) begin
            clear_plan();
            if ($urandom_range(0, 3) != 0)
                for (int c = 0; c < 100; c++) d_ack[c] = ($urandom_range(0, 15) == 0);
            run_frame(DW'($urandom), $sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
